// File: rtl/n64_vmux.sv
// N64 multiplexed video bus transmitter: raster timing plus 4-cycle slot
// serializer (sync word, R, G, B) fed by a one-slot-ahead pixel handshake.
module n64_vmux #(
  parameter int color_width = 7,
  parameter int H_TOTAL     = 773,
  parameter int H_SYNC      = 57,
  parameter int H_CLAMP     = 16,
  parameter int H_ACT_START = 108,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 263,
  parameter int V_SYNC      = 3,
  parameter int V_ACT_START = 20,
  parameter int V_ACTIVE    = 240
) (
  input  logic                   VCLK,
  input  logic                   nRST,
  input  logic                   enable_i,
  input  logic                   pix_valid_i,
  output logic                   pix_rdy_o,
  input  logic [color_width-1:0] pix_r_i,
  input  logic [color_width-1:0] pix_g_i,
  input  logic [color_width-1:0] pix_b_i,
  input  logic                   clr_underflow_i,
  output logic                   nDSYNC_o,
  output logic [color_width-1:0] D_o,
  output logic                   underflow_o,
  output logic                   frame_start_o
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int HX = HW + 1;
  localparam int VX = VW + 1;

  // Bounds carried one bit wider so end-of-range values never alias to 0.
  localparam logic [HX-1:0] H_LAST = HX'(H_TOTAL - 1);
  localparam logic [HX-1:0] HS_END = HX'(H_SYNC);
  localparam logic [HX-1:0] HC_END = HX'(H_SYNC + H_CLAMP);
  localparam logic [HX-1:0] HA_BEG = HX'(H_ACT_START);
  localparam logic [HX-1:0] HA_END = HX'(H_ACT_START + H_ACTIVE);
  localparam logic [VX-1:0] V_LAST = VX'(V_TOTAL - 1);
  localparam logic [VX-1:0] VS_END = VX'(V_SYNC);
  localparam logic [VX-1:0] VA_BEG = VX'(V_ACT_START);
  localparam logic [VX-1:0] VA_END = VX'(V_ACT_START + V_ACTIVE);

  typedef struct packed {
    logic [color_width-1:0] r;
    logic [color_width-1:0] g;
    logic [color_width-1:0] b;
  } pix_t;

  function automatic logic h_act(input logic [HW-1:0] h);
    return ({1'b0, h} >= HA_BEG) && ({1'b0, h} < HA_END);
  endfunction

  function automatic logic v_act(input logic [VW-1:0] v);
    return ({1'b0, v} >= VA_BEG) && ({1'b0, v} < VA_END);
  endfunction

  logic [1:0]             phase_q, phase_d;
  logic [HW-1:0]          hcnt_q, hcnt_d, hcnt_nx;
  logic [VW-1:0]          vcnt_q, vcnt_d, vcnt_nx;
  pix_t                   buf_q, buf_d;
  logic                   rdy_q, rdy_d;
  logic                   nds_q, nds_d;
  logic                   uf_q, uf_d;
  logic                   fs_q, fs_d;
  logic [color_width-1:0] d_q, d_d;
  logic                   h_wrap, v_wrap;
  logic                   hs, vs, clamp, act_nx;
  logic [color_width-1:0] sync_word;

  // Raster decode of the current slot and look-ahead to the following slot.
  always_comb begin
    h_wrap  = ({1'b0, hcnt_q} == H_LAST);
    v_wrap  = ({1'b0, vcnt_q} == V_LAST);
    hcnt_nx = h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_nx = vcnt_q;
    if (h_wrap) vcnt_nx = v_wrap ? '0 : vcnt_q + 1'b1;
    hs     = ({1'b0, hcnt_q} < HS_END);
    vs     = ({1'b0, vcnt_q} < VS_END);
    clamp  = ({1'b0, hcnt_q} >= HS_END) && ({1'b0, hcnt_q} < HC_END);
    act_nx = h_act(hcnt_nx) && v_act(vcnt_nx);
    sync_word      = '0;
    sync_word[3:0] = {~vs, ~clamp, ~hs, ~(hs ^ vs)};
  end

  always_comb begin
    phase_d = phase_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    buf_d   = buf_q;
    rdy_d   = rdy_q;
    nds_d   = nds_q;
    d_d     = d_q;
    fs_d    = fs_q;
    uf_d    = uf_q;

    // Set beats clear; a disabled block never flags a missing pixel.
    if (enable_i && rdy_q && !pix_valid_i) uf_d = 1'b1;
    else if (clr_underflow_i)              uf_d = 1'b0;

    if (!enable_i) begin
      phase_d = '0;
      hcnt_d  = '0;
      vcnt_d  = '0;
      rdy_d   = 1'b0;
      nds_d   = 1'b1;
      d_d     = '0;
      fs_d    = 1'b0;
    end else begin
      phase_d = phase_q + 2'd1;
      if (phase_q == 2'd3) begin
        hcnt_d = hcnt_nx;
        vcnt_d = vcnt_nx;
      end
      rdy_d = (phase_q == 2'd3) && act_nx;
      fs_d  = (phase_q == 2'd0) && (hcnt_q == '0) && (vcnt_q == '0);
      nds_d = (phase_q != 2'd0);
      case (phase_q)
        2'd0: begin
          d_d   = sync_word;
          // Slot buffer is zeroed for inactive or starved slots.
          buf_d = (rdy_q && pix_valid_i) ? {pix_r_i, pix_g_i, pix_b_i} : '0;
        end
        2'd1:    d_d = buf_q.r;
        2'd2:    d_d = buf_q.g;
        default: d_d = buf_q.b;
      endcase
    end
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      phase_q <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      buf_q   <= '0;
      rdy_q   <= 1'b0;
      nds_q   <= 1'b1;
      d_q     <= '0;
      uf_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      buf_q   <= buf_d;
      rdy_q   <= rdy_d;
      nds_q   <= nds_d;
      d_q     <= d_d;
      uf_q    <= uf_d;
      fs_q    <= fs_d;
    end
  end

  assign pix_rdy_o     = rdy_q;
  assign nDSYNC_o      = nds_q;
  assign D_o           = d_q;
  assign underflow_o   = uf_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_n64_vmux.sv
// Scoreboard bench for n64_vmux on a small raster; reference model indexes
// the output stream by cycle count since the last restart.
module tb_n64_vmux;
  localparam int CW = 7;
  localparam int HT = 12, HS = 2, HC = 2, HA = 5, HN = 4;
  localparam int VT = 6, VS = 1, VA = 2, VN = 2;
  localparam int FRAME = 4 * HT * VT;

  logic          VCLK = 1'b0;
  logic          nRST, enable_i, pix_valid_i, clr_underflow_i;
  logic [CW-1:0] pix_r_i, pix_g_i, pix_b_i;
  logic          pix_rdy_o, nDSYNC_o, underflow_o, frame_start_o;
  logic [CW-1:0] D_o;

  n64_vmux #(
    .color_width(CW), .H_TOTAL(HT), .H_SYNC(HS), .H_CLAMP(HC),
    .H_ACT_START(HA), .H_ACTIVE(HN), .V_TOTAL(VT), .V_SYNC(VS),
    .V_ACT_START(VA), .V_ACTIVE(VN)
  ) dut (
    .VCLK(VCLK), .nRST(nRST), .enable_i(enable_i),
    .pix_valid_i(pix_valid_i), .pix_rdy_o(pix_rdy_o),
    .pix_r_i(pix_r_i), .pix_g_i(pix_g_i), .pix_b_i(pix_b_i),
    .clr_underflow_i(clr_underflow_i), .nDSYNC_o(nDSYNC_o), .D_o(D_o),
    .underflow_o(underflow_o), .frame_start_o(frame_start_o)
  );

  always #5 VCLK = ~VCLK;

  typedef struct {
    logic          nd;
    logic [CW-1:0] d;
    logic          rdy;
    logic          uf;
    logic          fs;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // ---- reference model ----
  int            m_t   = 0;
  bit            m_rdy = 0;
  bit            m_uf  = 0;
  logic [CW-1:0] m_buf[3] = '{default: '0};

  function automatic logic [CW-1:0] sync_of(input int h, input int v);
    bit hs_, vs_, cl_;
    hs_ = (h < HS);
    vs_ = (v < VS);
    cl_ = (h >= HS) && (h < HS + HC);
    return {3'b000, !vs_, !cl_, !hs_, !(hs_ ^ vs_)};
  endfunction

  function automatic bit act_of(input int h, input int v);
    return (h >= HA) && (h < HA + HN) && (v >= VA) && (v < VA + VN);
  endfunction

  task automatic step_model(input bit rst, input bit en, input bit vld, input bit clr,
                            input logic [CW-1:0] r, input logic [CW-1:0] g,
                            input logic [CW-1:0] b);
    exp_t e;
    int   ph, h, v, nxt;
    bit   set;
    e.nd = 1'b1; e.d = '0; e.rdy = 1'b0; e.fs = 1'b0;
    if (!rst) begin
      m_t = 0; m_rdy = 0; m_uf = 0; m_buf = '{default: '0};
    end else begin
      set = en && m_rdy && !vld;
      if (en) begin
        ph = m_t % 4;
        h  = (m_t / 4) % HT;
        v  = (m_t / (4 * HT)) % VT;
        if (ph == 0) begin
          if (m_rdy && vld) m_buf = '{r, g, b};
          else              m_buf = '{default: '0};
          e.nd = 1'b0;
          e.d  = sync_of(h, v);
          e.fs = (h == 0) && (v == 0);
        end else begin
          e.d = m_buf[ph-1];
        end
        nxt   = (m_t + 1) % FRAME;
        e.rdy = (ph == 3) && act_of((nxt / 4) % HT, (nxt / (4 * HT)) % VT);
        m_t   = nxt;
      end else begin
        m_t = 0;
      end
      if (set)      m_uf = 1;
      else if (clr) m_uf = 0;
    end
    m_rdy = e.rdy;
    e.uf  = m_uf;
    q.push_back(e);
  endtask

  // ---- driver ----
  int k = 0;

  task automatic cyc(input bit rst, input bit en, input bit vld, input bit clr);
    logic [CW-1:0] r, g, b;
    r = CW'((3 * k + 1) % 128);
    g = CW'((3 * k + 2) % 128);
    b = CW'((3 * k + 3) % 128);
    nRST = rst; enable_i = en; pix_valid_i = vld; clr_underflow_i = clr;
    pix_r_i = r; pix_g_i = g; pix_b_i = b;
    if (rst && en && vld && m_rdy) k++;
    step_model(rst, en, vld, clr, r, g, b);
    @(posedge VCLK);
    @(negedge VCLK);
  endtask

  // ---- monitor ----
  initial begin
    exp_t e;
    forever begin
      @(posedge VCLK);
      #1;
      if (q.size() == 0) begin
        cmp("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        cmp("nDSYNC", nDSYNC_o, e.nd);
        cmp("D", D_o, e.d);
        cmp("pix_rdy", pix_rdy_o, e.rdy);
        cmp("underflow", underflow_o, e.uf);
        cmp("frame_start", frame_start_o, e.fs);
      end
    end
  end

  initial begin
    int  rdy_cnt;
    bit  found;
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0);

    // first frame after reset with a pixel always offered
    rdy_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc(1, 1, 1, 0);
      if (pix_rdy_o === 1'b1) rdy_cnt++;
    end
    cmp("rdy_per_frame", rdy_cnt, HN * VN);
    for (int i = 0; i < FRAME; i++) cyc(1, 1, 1, 0);

    // starve one active slot, then clear, then starve and clear together
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (m_rdy) begin cyc(1, 1, 0, 0); found = 1; end
      else cyc(1, 1, 1, 0);
    end
    cmp("starve_window", found, 1);
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 1);
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (m_rdy) begin cyc(1, 1, 0, 1); found = 1; end
      else cyc(1, 1, 1, 0);
    end
    cmp("set_clr_window", found, 1);
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0);

    // drop enable mid-line at phase 2, underflow still set
    while (!((m_t % 4) == 2 && (m_t / 4) % HT > HS + HC)) cyc(1, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
    for (int i = 0; i < FRAME + 10; i++) cyc(1, 1, 1, 0);

    // randomized traffic with a mid-frame reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500 || i == 1501) cyc(0, 1, 1, 0);
      else cyc(1, ($urandom_range(99) != 0), ($urandom_range(99) < 80),
               ($urandom_range(99) < 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
